// File: rtl/rx_ppe_ch_arb.sv
// Multi-channel RX PPE ingress: per-channel flit FIFOs merged by a packet-locked
// round-robin arbiter into one channel-tagged, registered output stream.
module rx_ppe_ch_arb #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4,
   parameter int CH_W   = $clog2(NUM_CH > 1 ? NUM_CH : 2)
) (
   input  logic                     cclk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_sop,
   input  logic [NUM_CH-1:0]        in_eop,
   input  logic [NUM_CH-1:0]        cfg_ch_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_sop,
   output logic                     out_eop,
   output logic [CH_W-1:0]          out_ch,
   output logic [NUM_CH-1:0]        err_orphan
);

   // state    | meaning
   // S_IDLE   | between packets; scan from r_rr_ptr for an enabled SOP head, drop orphan heads
   // S_LOCKED | mid-packet on r_lock_ch; only that FIFO feeds the output until EOP

   localparam int AW = $clog2(DEPTH);
   localparam int EW = DATA_W + 2;
   localparam logic [CH_W:0]   NCH     = (CH_W+1)'(NUM_CH);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t            r_state;
   logic [CH_W-1:0]   r_rr_ptr;
   logic [CH_W-1:0]   r_lock_ch;
   logic [AW:0]       r_wptr [NUM_CH];
   logic [AW:0]       r_rptr [NUM_CH];
   logic [EW-1:0]     r_mem  [NUM_CH][DEPTH];
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_sop;
   logic              r_out_eop;
   logic [CH_W-1:0]   r_out_ch;
   logic [NUM_CH-1:0] r_err_orphan;

   logic [NUM_CH-1:0] w_empty, w_full, w_hsop, w_push, w_pop, w_orphan;
   logic [EW-1:0]     w_head [NUM_CH];
   logic              w_load_ok;
   logic              w_found;
   logic [CH_W-1:0]   w_sel;
   logic [CH_W:0]     w_idx;
   logic [EW-1:0]     w_sel_head;
   logic [CH_W-1:0]   w_rr_next;

   always_comb begin
      w_empty = '0;
      w_full  = '0;
      w_hsop  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_empty[c] = (r_wptr[c] == r_rptr[c]);
         w_full[c]  = (r_wptr[c][AW] != r_rptr[c][AW]) &&
                      (r_wptr[c][AW-1:0] == r_rptr[c][AW-1:0]);
         w_head[c]  = r_mem[c][r_rptr[c][AW-1:0]];
         w_hsop[c]  = w_head[c][EW-1];
      end
   end

   // Ready depends only on registered occupancy and reset, never on out_ready.
   assign in_ready  = reset ? ~w_full : '0;
   assign w_push    = in_valid & in_ready;
   assign w_load_ok = !r_out_valid || out_ready;

   always_comb begin
      w_found  = 1'b0;
      w_sel    = '0;
      w_idx    = '0;
      w_orphan = '0;
      if (r_state == S_IDLE) begin
         w_orphan = ~w_empty & ~w_hsop;
         if (w_load_ok) begin
            for (int i = 0; i < NUM_CH; i++) begin
               w_idx = {1'b0, r_rr_ptr} + (CH_W+1)'(i);
               if (w_idx >= NCH) w_idx = w_idx - NCH;
               if (!w_found && !w_empty[w_idx[CH_W-1:0]] && w_hsop[w_idx[CH_W-1:0]] &&
                   cfg_ch_en[w_idx[CH_W-1:0]]) begin
                  w_found = 1'b1;
                  w_sel   = w_idx[CH_W-1:0];
               end
            end
         end
      end else if (w_load_ok && !w_empty[r_lock_ch]) begin
         w_found = 1'b1;
         w_sel   = r_lock_ch;
      end
      w_pop = w_orphan;
      if (w_found) w_pop[w_sel] = 1'b1;
      w_sel_head = w_head[w_sel];
      w_rr_next  = (w_sel == LAST_CH) ? '0 : w_sel + CH_W'(1);
   end

   always_ff @(posedge cclk) begin
      for (int c = 0; c < NUM_CH; c++)
         if (w_push[c])
            r_mem[c][r_wptr[c][AW-1:0]] <= {in_sop[c], in_eop[c], in_data[c*DATA_W +: DATA_W]};
   end

   always_ff @(posedge cclk) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_rr_ptr     <= '0;
         r_lock_ch    <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_sop    <= 1'b0;
         r_out_eop    <= 1'b0;
         r_out_ch     <= '0;
         r_err_orphan <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_wptr[c] <= '0;
            r_rptr[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_push[c]) r_wptr[c] <= r_wptr[c] + (AW+1)'(1);
            if (w_pop[c])  r_rptr[c] <= r_rptr[c] + (AW+1)'(1);
         end
         r_err_orphan <= w_orphan;
         if (w_found) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_head[DATA_W-1:0];
            r_out_sop   <= w_sel_head[EW-1];
            r_out_eop   <= w_sel_head[EW-2];
            r_out_ch    <= w_sel;
            if (r_state == S_IDLE) begin
               r_rr_ptr <= w_rr_next;
               if (!w_sel_head[EW-2]) begin
                  r_state   <= S_LOCKED;
                  r_lock_ch <= w_sel;
               end
            end else if (w_sel_head[EW-2]) begin
               r_state <= S_IDLE;
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_sop    = r_out_sop;
   assign out_eop    = r_out_eop;
   assign out_ch     = r_out_ch;
   assign err_orphan = r_err_orphan;

endmodule

// File: tb/tb_rx_ppe_ch_arb.sv
// Directed bench for rx_ppe_ch_arb: reset, latency, round-robin locking,
// backpressure, channel disable and orphan dropping.
module tb_rx_ppe_ch_arb;

   logic         cclk = 1'b0;
   logic         reset;
   logic [3:0]   in_valid, in_ready, in_sop, in_eop, cfg_ch_en, err_orphan;
   logic [255:0] in_data;
   logic         out_valid, out_ready, out_sop, out_eop;
   logic [63:0]  out_data;
   logic [1:0]   out_ch;

   int           n_pass  = 0;
   int           n_total = 0;
   int           cyc_cnt = 0;
   logic [23:0]  q_rec [$];
   logic [23:0]  q_exp [$];
   int           q_t   [$];

   rx_ppe_ch_arb dut (
      .cclk(cclk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sop(in_sop), .in_eop(in_eop), .cfg_ch_en(cfg_ch_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sop(out_sop), .out_eop(out_eop), .out_ch(out_ch),
      .err_orphan(err_orphan)
   );

   always #5 cclk = ~cclk;
   always @(posedge cclk) cyc_cnt++;

   // Capture each accepted output flit just before the edge that transfers it.
   always @(negedge cclk) begin
      #3;
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         q_rec.push_back({2'b00, out_ch, 2'b00, out_sop, out_eop, out_data[15:0]});
         q_t.push_back(cyc_cnt);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   function automatic logic [23:0] rec(input int ch, input bit s, input bit e, input logic [15:0] d);
      return {4'(ch), 2'b00, s, e, d};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic chk_q(input string tag);
      chk({tag, " count"}, 32'(q_rec.size()), 32'(q_exp.size()));
      for (int i = 0; i < q_exp.size(); i++)
         chk($sformatf("%s[%0d]", tag, i),
             (i < q_rec.size()) ? 32'(q_rec[i]) : 32'hFFFF_FFFF, 32'(q_exp[i]));
      q_rec.delete();
      q_t.delete();
      q_exp.delete();
   endtask

   task automatic tick();
      @(negedge cclk);
      #1;
   endtask

   task automatic clr();
      in_valid = '0;
      in_sop   = '0;
      in_eop   = '0;
   endtask

   task automatic put(input int c, input bit s, input bit e, input logic [15:0] d);
      in_valid[c] = 1'b1;
      in_sop[c]   = s;
      in_eop[c]   = e;
      in_data[c*64 +: 64] = 64'(d);
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 4'hF;
      in_sop    = '0;
      in_eop    = '0;
      in_data   = '0;
      cfg_ch_en = 4'hF;
      out_ready = 1'b1;

      // Reset held for three cycles with all valids high.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rst in_ready %0d", i), 32'(in_ready), 32'h0);
         chk($sformatf("rst out_valid %0d", i), 32'(out_valid), 32'h0);
      end
      chk("rst err_orphan", 32'(err_orphan), 32'h0);
      clr();
      reset = 1'b1;
      tick();
      chk("post-rst in_ready", 32'(in_ready), 32'hF);
      tick();
      tick();
      chk("idle out_valid", 32'(out_valid), 32'h0);

      // Single-flit latency on channel 2.
      put(2, 1, 1, 16'hA5);
      tick();
      clr();
      chk("lat out_valid k", 32'(out_valid), 32'h0);
      tick();
      chk("lat out_valid k+1", 32'(out_valid), 32'h1);
      chk("lat out_ch", 32'(out_ch), 32'h2);
      chk("lat out_data", out_data[31:0], 32'hA5);
      chk("lat sop/eop", {30'd0, out_sop, out_eop}, 32'h3);
      tick();
      chk("lat out_valid k+2", 32'(out_valid), 32'h0);
      q_exp.push_back(rec(2, 1, 1, 16'hA5));
      chk_q("lat stream");

      // Round-robin with packet lock, starting from a fresh reset (rr_ptr=0).
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      q_rec.delete();
      q_t.delete();
      put(0, 1, 0, 16'h00); put(1, 1, 0, 16'h10); put(3, 1, 1, 16'h30);
      tick(); clr();
      put(0, 0, 0, 16'h01); put(1, 0, 0, 16'h11);
      tick(); clr();
      put(0, 0, 1, 16'h02); put(1, 0, 1, 16'h12);
      tick(); clr();
      repeat (10) tick();
      q_exp.push_back(rec(0, 1, 0, 16'h00));
      q_exp.push_back(rec(0, 0, 0, 16'h01));
      q_exp.push_back(rec(0, 0, 1, 16'h02));
      q_exp.push_back(rec(1, 1, 0, 16'h10));
      q_exp.push_back(rec(1, 0, 0, 16'h11));
      q_exp.push_back(rec(1, 0, 1, 16'h12));
      q_exp.push_back(rec(3, 1, 1, 16'h30));
      chk_q("rr lock");

      // rr_ptr wrapped to 0 after ch3: ch0 wins over a simultaneous ch3.
      put(3, 1, 1, 16'h31); put(0, 1, 1, 16'h03);
      tick(); clr();
      repeat (4) tick();
      q_exp.push_back(rec(0, 1, 1, 16'h03));
      q_exp.push_back(rec(3, 1, 1, 16'h31));
      chk_q("rr wrap");

      // Backpressure: one flit in the output register, four in the FIFO.
      out_ready = 1'b0;
      put(1, 1, 0, 16'h40); tick(); clr();
      put(1, 0, 0, 16'h41); tick(); clr();
      put(1, 0, 0, 16'h42); tick(); clr();
      put(1, 0, 0, 16'h43); tick(); clr();
      chk("bp in_ready before 5th", 32'(in_ready[1]), 32'h1);
      put(1, 0, 1, 16'h44); tick(); clr();
      chk("bp in_ready full", 32'(in_ready[1]), 32'h0);
      chk("bp out_valid held", 32'(out_valid), 32'h1);
      chk("bp out_data held", out_data[31:0], 32'h40);
      chk("bp out_ch held", 32'(out_ch), 32'h1);
      put(1, 1, 1, 16'h45); tick(); clr();
      chk("bp 6th refused", 32'(in_ready[1]), 32'h0);
      chk("bp out_data stable", out_data[31:0], 32'h40);
      out_ready = 1'b1;
      repeat (8) tick();
      chk("bp drain rate", (q_t.size() == 5) ? 32'(q_t[4] - q_t[0]) : 32'hFFFF_FFFF, 32'h4);
      q_exp.push_back(rec(1, 1, 0, 16'h40));
      q_exp.push_back(rec(1, 0, 0, 16'h41));
      q_exp.push_back(rec(1, 0, 0, 16'h42));
      q_exp.push_back(rec(1, 0, 0, 16'h43));
      q_exp.push_back(rec(1, 0, 1, 16'h44));
      chk_q("bp drain");

      // Disable ch0 after its SOP is granted: the packet still completes.
      put(0, 1, 0, 16'h50); tick(); clr();
      put(0, 0, 0, 16'h51); tick(); clr();
      cfg_ch_en[0] = 1'b0;
      put(0, 0, 0, 16'h52); tick(); clr();
      put(0, 0, 1, 16'h53); tick(); clr();
      repeat (4) tick();
      q_exp.push_back(rec(0, 1, 0, 16'h50));
      q_exp.push_back(rec(0, 0, 0, 16'h51));
      q_exp.push_back(rec(0, 0, 0, 16'h52));
      q_exp.push_back(rec(0, 0, 1, 16'h53));
      chk_q("dis mid-pkt");
      put(0, 1, 1, 16'h60); tick(); clr();
      repeat (4) tick();
      chk_q("dis held");
      put(1, 1, 1, 16'h70); tick(); clr();
      repeat (3) tick();
      q_exp.push_back(rec(1, 1, 1, 16'h70));
      chk_q("dis ch1 passes");
      cfg_ch_en = 4'hF;
      repeat (3) tick();
      q_exp.push_back(rec(0, 1, 1, 16'h60));
      chk_q("dis re-enable");

      // Orphan flit on ch3 while idle.
      put(3, 0, 0, 16'h11); tick(); clr();
      chk("orph err before", 32'(err_orphan), 32'h0);
      tick();
      chk("orph err pulse", 32'(err_orphan), 32'h8);
      chk("orph out_valid", 32'(out_valid), 32'h0);
      tick();
      chk("orph err clear", 32'(err_orphan), 32'h0);
      put(3, 1, 1, 16'h12); tick(); clr();
      repeat (3) tick();
      q_exp.push_back(rec(3, 1, 1, 16'h12));
      chk_q("orph follow-up");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
